// File: rtl/accel_mem_ctrl.sv
// SHA accelerator memory-port initiator: fetches one 64-byte block for the accel, then writes
// the 256-bit result back as word beats over the memory port shared with the CPU.
module accel_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 512,
  parameter int WORD_W = 32,
  parameter int RES_W  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wrt_data,
  output logic              mem_wrt_en,
  input  logic [BLK_W-1:0]  mem_rd_data,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  input  logic [RES_W-1:0]  res_data,
  input  logic              res_valid,
  output logic              res_ready
);

  localparam int BEATS   = RES_W / WORD_W;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(WORD_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    OFFER,
    WAIT_RES,
    WR_BURST,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_lat, dst_lat;
  logic [RES_W-1:0]  res_lat;
  logic [BEAT_W-1:0] beat;

  // Byte address of a write beat; truncation to ADDR_W gives the mod-2^ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] idx);
    return base + (ADDR_W'(idx) << BYTE_SH);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_lat  <= '0;
      dst_lat  <= '0;
      res_lat  <= '0;
      beat     <= '0;
      blk_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_lat <= src_addr;
            dst_lat <= dst_addr;
          end
        end
        RD_CAP: blk_data <= mem_rd_data;
        WAIT_RES: begin
          if (res_valid) begin
            res_lat <= res_data;
            beat    <= '0;
          end
        end
        WR_BURST: begin
          if (mem_gnt) beat <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt_en   = 1'b0;
    blk_valid    = 1'b0;
    res_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = src_lat;
        if (mem_gnt) state_nxt = RD_CAP;
      end
      RD_CAP: state_nxt = OFFER;
      OFFER: begin
        blk_valid = 1'b1;
        if (blk_ready) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) state_nxt = WR_BURST;
      end
      WR_BURST: begin
        mem_req      = 1'b1;
        mem_addr     = beat_addr(dst_lat, beat);
        mem_wrt_data = res_lat[int'(beat)*WORD_W +: WORD_W];
        // Strobe is masked by rst so a reset mid-burst aborts before the current beat lands.
        mem_wrt_en   = mem_gnt & ~rst;
        if (mem_gnt && beat == LAST_BEAT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accel_mem_ctrl.sv
// Bench for accel_mem_ctrl: byte-array memory, accel responder, and a scoreboard monitor that
// compares offered blocks, write beats and done pulses against a queue-based reference model.
module tb_accel_mem_ctrl;
  localparam int ADDR_W = 16;
  localparam int BLK_W  = 512;
  localparam int WORD_W = 32;
  localparam int RES_W  = 256;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              busy, done, mem_req, mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wrt_data;
  logic              mem_wrt_en;
  logic [BLK_W-1:0]  mem_rd_data, blk_data;
  logic              blk_valid, blk_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_valid, res_ready;

  accel_mem_ctrl #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .WORD_W(WORD_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en), .mem_rd_data(mem_rd_data),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0, miscompares = 0;
  logic [7:0]   mem [65536];
  logic [511:0] exp_blk_q[$];
  logic [47:0]  exp_wr_q[$];
  int exp_done = 0, wr_seen = 0, done_seen = 0, cyc = 0, hs_cyc = -100;
  bit lat_chk = 1'b0, gnt_rand = 1'b0;
  logic gnt_hold = 1'b1;
  int blk_dly = 0, res_dly = 0;
  logic [255:0] res_next = '0;
  logic [15:0]  cur_dst = '0;
  logic [15:0]  mm_a;
  logic         mm_we;
  logic [31:0]  mm_d;

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model_block(input logic [15:0] a);
    logic [511:0] b;
    for (int k = 0; k < 64; k++) b[8*k +: 8] = mem[16'(a + 16'(k))];
    return b;
  endfunction

  function automatic logic [255:0] mem_range32(input logic [15:0] a);
    logic [255:0] b;
    for (int k = 0; k < 32; k++) b[8*k +: 8] = mem[16'(a + 16'(k))];
    return b;
  endfunction

  task automatic chk_quiet(input string name);
    chk_i({name, "_ctl"}, int'({busy, done, mem_req, mem_wrt_en, blk_valid, res_ready}), 0);
    chk_i({name, "_addr"}, int'(mem_addr), 0);
    chk_i({name, "_wdata"}, int'(mem_wrt_data), 0);
    chk_w({name, "_blk"}, blk_data, '0);
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input bit accept);
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d;
    chk_i("start_vs_busy", int'(busy), int'(!accept));
    if (accept) begin
      exp_blk_q.push_back(model_block(s));
      exp_done++;
      cur_dst = d;
    end
    @(posedge clk); #1;
    start = 1'b0; src_addr = 16'($urandom); dst_addr = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    chk_i({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_beats(input string name, input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (wr_seen >= n) break;
    end
    chk_i({name, "_beats"}, int'(wr_seen >= n), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Arbiter model: tied, scripted, or random grant.
  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge clk); #2;
      mem_gnt = gnt_rand ? logic'($urandom_range(3, 0) != 0) : gnt_hold;
    end
  end

  // Data memory: byte writes, registered 64-byte read one cycle after the address.
  initial begin
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mm_a = mem_addr; mm_we = mem_wrt_en; mm_d = mem_wrt_data;
      @(posedge clk); #1;
      if (mm_we) for (int b = 0; b < 4; b++) mem[16'(mm_a + 16'(b))] = mm_d[8*b +: 8];
      mem_rd_data = model_block(mm_a);
    end
  end

  // Accelerator: accepts the block after blk_dly cycles, offers res_next after res_dly cycles.
  initial begin
    bit got;
    blk_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      if (blk_valid && !blk_ready && !rst) begin
        @(posedge clk);
        repeat (blk_dly) @(posedge clk);
        #1 blk_ready = 1'b1;
        @(posedge clk); #1 blk_ready = 1'b0;
        for (int i = 0; i < res_dly; i++) begin
          @(posedge clk); #1;
        end
        res_data = res_next; res_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
          @(negedge clk);
          if (res_ready) begin
            got = 1'b1;
            hs_cyc = cyc;
            for (int k = 0; k < 8; k++)
              exp_wr_q.push_back({16'(cur_dst + 16'(4*k)), res_data[32*k +: 32]});
          end
        end
        chk_i("res_handshake", int'(got), 1);
        @(posedge clk); #1 res_valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wrt_en) chk_i("wrt_en_without_gnt", int'(mem_gnt), 1);
        if (!mem_req) chk_i("bus_idle_zero", int'(mem_addr) | int'(mem_wrt_data) | int'(mem_wrt_en), 0);
        if (blk_valid && blk_ready) begin
          if (exp_blk_q.size() == 0) chk_i("blk_unexpected", int'(blk_valid), 0);
          else chk_w("blk_data", blk_data, exp_blk_q.pop_front());
        end
        if (mem_wrt_en) begin
          wr_seen++;
          if (exp_wr_q.size() == 0) chk_i("wr_unexpected", int'(mem_wrt_en), 0);
          else chk_w("wr_beat", 512'({mem_addr, mem_wrt_data}), 512'(exp_wr_q.pop_front()));
        end
        if (done) begin
          done_seen++;
          chk_i("done_busy", int'(busy), 1);
          if (exp_done == 0) chk_i("done_unexpected", int'(done), 0);
          else exp_done--;
          if (lat_chk) chk_i("res_to_done_cycles", cyc - hs_cyc, 9);
        end
      end
    end
  end

  initial begin
    int d0;
    logic [255:0] old_a;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem[16'h1000 + i] = 8'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Block fetch latency and byte order, then result write-back to 0x9000.
    for (int k = 0; k < 32; k++) res_next[8*k +: 8] = 8'(k + 1);
    lat_chk = 1'b1; blk_dly = 0; res_dly = 0; gnt_hold = 1'b1;
    d0 = done_seen;
    pulse_start(16'h1000, 16'h9000, 1'b1);
    @(negedge clk); chk_i("t1_blk_valid_c1", int'(blk_valid), 0);
    @(negedge clk); chk_i("t1_blk_valid_c2", int'(blk_valid), 0);
    @(negedge clk); chk_i("t1_blk_valid_c3", int'(blk_valid), 1);
    chk_i("t1_byte0", int'(blk_data[7:0]), 'h00);
    chk_i("t1_byte63", int'(blk_data[511:504]), 'h3F);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_wrt_en) break;
    end
    chk_i("t2_first_addr", int'(mem_addr), 'h9000);
    chk_w("t2_first_data", 512'(mem_wrt_data), 512'(32'h0403_0201));
    wait_idle("t2");
    chk_i("t2_done_count", done_seen - d0, 1);
    chk_w("t2_mem", 512'(mem_range32(16'h9000)), 512'(res_next));
    lat_chk = 1'b0;

    // Grant withheld in RD_REQ, then dropped for two cycles at beat 3.
    res_next = {8{$urandom}};
    gnt_hold = 1'b0; wr_seen = 0;
    pulse_start(16'h2000, 16'h9000, 1'b1);
    repeat (2) @(negedge clk);
    chk_i("t3_rdreq_stall", int'({mem_req, busy}), 3);
    chk_i("t3_rdreq_addr", int'(mem_addr), 'h2000);
    @(posedge clk); @(posedge clk); #1 gnt_hold = 1'b1;
    wait_beats("t3_b3", 3);
    @(posedge clk); #1 gnt_hold = 1'b0;
    @(negedge clk);
    chk_i("t3_stall_addr", int'(mem_addr), 'h900C);
    chk_i("t3_stall_wen", int'(mem_wrt_en), 0);
    @(negedge clk);
    chk_i("t3_stall2_wen", int'(mem_wrt_en), 0);
    @(posedge clk); #1 gnt_hold = 1'b1;
    wait_idle("t3");
    chk_i("t3_beats", wr_seen, 8);

    // Destination wrapping through 0xFFFF.
    res_next = {8{$urandom}};
    pulse_start(16'h1000, 16'hFFF0, 1'b1);
    wait_idle("t4");
    chk_w("t4_top_word", 512'({mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]}), 512'(res_next[127:96]));
    chk_w("t4_wrap_word", 512'({mem[16'h0003], mem[16'h0002], mem[16'h0001], mem[16'h0000]}), 512'(res_next[159:128]));

    // Starts during OFFER and during DONE are ignored.
    res_next = {8{$urandom}};
    blk_dly = 4; res_dly = 2; wr_seen = 0; d0 = done_seen;
    pulse_start(16'h3000, 16'h5000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (blk_valid) break;
    end
    chk_i("t5_offer", int'(blk_valid), 1);
    pulse_start(16'h4444, 16'h6666, 1'b0);
    wait_beats("t5_last", 8);
    pulse_start(16'h7777, 16'h8888, 1'b0);
    @(negedge clk);
    chk_i("t5_no_restart", int'(busy), 0);
    chk_i("t5_done_count", done_seen - d0, 1);
    blk_dly = 0; res_dly = 0;

    // Reset while beat 4 is on the bus.
    res_next = {8{$urandom}};
    old_a = mem_range32(16'hA000);
    wr_seen = 0;
    pulse_start(16'h1000, 16'hA000, 1'b1);
    wait_beats("t6_b4", 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("t6_reset");
    #1;
    chk_i("t6_pending_beats", exp_wr_q.size(), 4);
    exp_wr_q.delete();
    chk_i("t6_pending_done", exp_done, 1);
    exp_done = 0;
    repeat (3) @(negedge clk);
    chk_w("t6_mem", 512'(mem_range32(16'hA000)), 512'({old_a[255:128], res_next[127:0]}));

    // Randomized traffic with random grant and handshake delays.
    gnt_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      res_next = {8{$urandom}};
      blk_dly = int'($urandom_range(4, 0));
      res_dly = int'($urandom_range(4, 0));
      pulse_start(16'($urandom), 16'($urandom), 1'b1);
      wait_idle("rand");
    end
    gnt_rand = 1'b0;
    repeat (3) @(negedge clk);
    chk_i("end_blk_q", exp_blk_q.size(), 0);
    chk_i("end_wr_q", exp_wr_q.size(), 0);
    chk_i("end_done", exp_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
